// File: rtl/fft_pkg.sv
// Shared FFT metadata-path definitions: bank state encoding, bank count and a
// width helper used by the mstore scheduler and its trackers.
package fft_pkg;

  localparam int unsigned MSTORE_BANKS = 2;

  typedef enum logic {
    FILLING  = 1'b0,
    DRAINING = 1'b1
  } mstore_state_t;

  // Minimum index width for a counter over 0..value-1; never returns 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/mstore_sched_if.sv
// Handshake and bank-steering bundle of the mstore ping-pong scheduler.
// The scheduler takes the slave view; producer, consumer and banks the master view.
interface mstore_sched_if #(
  parameter int unsigned MWIDTH = 1
);
  import fft_pkg::*;

  logic                           in_nd;
  logic                           in_ready;
  logic                           rd_req;
  logic                           out_valid;
  logic [MWIDTH-1:0]              out_m;
  logic                           out_last;
  logic [MSTORE_BANKS-1:0]        bank_nd;
  logic [MSTORE_BANKS-1:0]        bank_read;
  logic [MSTORE_BANKS*MWIDTH-1:0] bank_m;
  logic                           error;

  modport master (
    output in_nd, rd_req, bank_m,
    input  in_ready, out_valid, out_m, out_last, bank_nd, bank_read, error
  );

  modport slave (
    input  in_nd, rd_req, bank_m,
    output in_ready, out_valid, out_m, out_last, bank_nd, bank_read, error
  );

endinterface

// File: rtl/mstore_bank_tracker.sv
// Shadow of one mstore bank: FILLING/DRAINING state plus the index counter that
// mirrors the bank's internal address, advanced by the strobes forwarded to it.
module mstore_bank_tracker
  import fft_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          rd,
  output mstore_state_t state,
  output logic [IW-1:0] index,
  output logic          last
);

  mstore_state_t state_q, state_d;
  logic [IW-1:0] index_q, index_d;

  assign last  = (index_q == IW'(N - 1));
  assign state = state_q;
  assign index = index_q;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      FILLING: begin
        if (wr) begin
          if (last) begin
            state_d = DRAINING;
            index_d = '0;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      DRAINING: begin
        if (rd) begin
          if (last) begin
            state_d = FILLING;
            index_d = '0;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILLING;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

endmodule

// File: rtl/mstore_sched.sv
// Ping-pong scheduler for two mstore banks: write/read pointers, strobe steering,
// output mux and sticky protocol-error flag. MSTORE_SCHED_ERRCNT_EN adds err_count.
module mstore_sched
  import fft_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned MWIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mstore_sched_if.slave  bus
`ifdef MSTORE_SCHED_ERRCNT_EN
  ,
  output logic [7:0]     err_count
`endif
);

  localparam int unsigned IW = clog2(N);

  mstore_state_t           state [MSTORE_BANKS];
  logic [IW-1:0]           index [MSTORE_BANKS];
  logic [MSTORE_BANKS-1:0] last;
  logic [MSTORE_BANKS-1:0] wr;
  logic [MSTORE_BANKS-1:0] rd;

  logic wr_bank_q, rd_bank_q;
  logic wr_acc, rd_acc;
  logic viol_wr, viol_rd;
  logic error_q;

  assign bus.in_ready  = (state[wr_bank_q] == FILLING);
  assign bus.out_valid = (state[rd_bank_q] == DRAINING);

  assign wr_acc  = bus.in_nd & bus.in_ready;
  assign rd_acc  = bus.rd_req & bus.out_valid;
  // Rejected strobes are flagged only; they never reach a bank.
  assign viol_wr = bus.in_nd & ~bus.in_ready;
  assign viol_rd = bus.rd_req & ~bus.out_valid;

  for (genvar b = 0; b < MSTORE_BANKS; b++) begin : g_bank
    assign wr[b] = wr_acc & (wr_bank_q == 1'(b));
    assign rd[b] = rd_acc & (rd_bank_q == 1'(b));

    mstore_bank_tracker #(
      .N (N)
    ) u_tracker (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[b]),
      .rd    (rd[b]),
      .state (state[b]),
      .index (index[b]),
      .last  (last[b])
    );
  end

  assign bus.bank_nd   = wr;
  assign bus.bank_read = rd;
  assign bus.out_m     = rd_bank_q ? bus.bank_m[2*MWIDTH-1:MWIDTH] : bus.bank_m[MWIDTH-1:0];
  assign bus.out_last  = bus.out_valid & (index[rd_bank_q] == IW'(N - 1));
  assign bus.error     = error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (wr_acc && last[wr_bank_q]) wr_bank_q <= ~wr_bank_q;
      if (rd_acc && last[rd_bank_q]) rd_bank_q <= ~rd_bank_q;
      error_q <= error_q | viol_wr | viol_rd;
    end
  end

`ifdef MSTORE_SCHED_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_cnt_sum;

  always_comb begin
    err_cnt_sum = {1'b0, err_cnt_q} + 9'(viol_wr) + 9'(viol_rd);
    err_cnt_d   = err_cnt_sum[8] ? 8'hff : err_cnt_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mstore_sched.sv
// Self-checking bench for mstore_sched (N=4, MWIDTH=4): behavioural bank models,
// a block-queue reference model, a vector table, corner sequences and random traffic.
module tb_mstore_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mstore_sched_if #(.MWIDTH(MW)) bus ();

`ifdef MSTORE_SCHED_ERRCNT_EN
  logic [7:0] err_count;
  mstore_sched #(.N(N), .MWIDTH(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                          .err_count(err_count));
`else
  mstore_sched #(.N(N), .MWIDTH(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int compared = 0;
  int mismatched = 0;

  // Environment: two behavioural mstore banks driven by the DUT strobes.
  logic [MW-1:0] bmem [2][N];
  int            baddr [2];
  logic [MW-1:0] din;
  logic [1:0]    cap_nd, cap_rd;

  // Reference model: completed-block values in arrival order plus the partial block.
  int rdq[$];
  int fq[$];
  int filled, drained, rpos, rerr_cnt;
  bit rerr;

  // Expectations for the current cycle.
  bit         e_ready, e_valid, e_last;
  logic [1:0] e_bnd, e_brd;
  int         e_m;

  typedef struct {
    bit         nd;
    bit         rd;
    logic [3:0] d;
    bit         e_ready;
    bit         e_valid;
    logic [3:0] e_m;
    bit         e_last;
    logic [1:0] e_bnd;
    logic [1:0] e_brd;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bank_m();
    bus.bank_m = {bmem[1][baddr[1]], bmem[0][baddr[0]]};
  endtask

  task automatic reset_models();
    rdq.delete();
    fq.delete();
    filled = 0; drained = 0; rpos = 0; rerr_cnt = 0; rerr = 0;
    for (int b = 0; b < 2; b++) begin
      baddr[b] = 0;
      for (int i = 0; i < N; i++) bmem[b][i] = '0;
    end
    drive_bank_m();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.in_nd = 1'b0; bus.rd_req = 1'b0;
    @(posedge clk);
    reset_models();
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_vals();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_bank_nd", 32'(bus.bank_nd), 32'd0);
    chk("rst_bank_read", 32'(bus.bank_read), 32'd0);
`ifdef MSTORE_SCHED_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
  endtask

  // Drive one cycle's strobes and compare all outputs against the model.
  task automatic apply(input bit nd, input bit rd, input logic [MW-1:0] d);
    int nblk;
    @(negedge clk);
    bus.in_nd = nd; bus.rd_req = rd; din = d;
    #1;
    nblk    = filled - drained;
    e_ready = (nblk < 2);
    e_valid = (nblk > 0);
    e_bnd   = (nd && e_ready) ? 2'(1 << (filled % 2)) : 2'b00;
    e_brd   = (rd && e_valid) ? 2'(1 << (drained % 2)) : 2'b00;
    e_last  = e_valid && (rpos == N - 1);
    e_m     = e_valid ? rdq[0] : 0;
    chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("out_last", 32'(bus.out_last), 32'(e_last));
    chk("bank_nd", 32'(bus.bank_nd), 32'(e_bnd));
    chk("bank_read", 32'(bus.bank_read), 32'(e_brd));
    chk("error", 32'(bus.error), 32'(rerr));
    if (e_valid) chk("out_m", 32'(bus.out_m), 32'(e_m));
`ifdef MSTORE_SCHED_ERRCNT_EN
    chk("err_count", 32'(err_count), 32'(rerr_cnt));
`endif
    cap_nd = bus.bank_nd;
    cap_rd = bus.bank_read;
  endtask

  task automatic advance();
    bit acc_w, acc_r;
    int nblk;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (cap_nd[b]) begin
        bmem[b][baddr[b]] = din;
        baddr[b] = (baddr[b] == N - 1) ? 0 : baddr[b] + 1;
      end
      if (cap_rd[b]) baddr[b] = (baddr[b] == N - 1) ? 0 : baddr[b] + 1;
    end
    drive_bank_m();
    nblk  = filled - drained;
    acc_w = bus.in_nd && (nblk < 2);
    acc_r = bus.rd_req && (nblk > 0);
    if (bus.in_nd && !acc_w) begin rerr = 1; rerr_cnt = (rerr_cnt < 255) ? rerr_cnt + 1 : 255; end
    if (bus.rd_req && !acc_r) begin rerr = 1; rerr_cnt = (rerr_cnt < 255) ? rerr_cnt + 1 : 255; end
    if (acc_r) begin
      void'(rdq.pop_front());
      rpos++;
      if (rpos == N) begin rpos = 0; drained++; end
    end
    if (acc_w) begin
      fq.push_back(int'(din));
      if (fq.size() == N) begin
        foreach (fq[i]) rdq.push_back(fq[i]);
        fq.delete();
        filled++;
      end
    end
  endtask

  task automatic step(input bit nd, input bit rd, input logic [MW-1:0] d);
    apply(nd, rd, d);
    advance();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_nd = 1'b0; bus.rd_req = 1'b0; din = '0;
    reset_models();

    //            nd rd  d  rdy vld  m  last bnd    brd
    tbl[0] = '{1, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00};
    tbl[1] = '{1, 0, 2, 1, 0, 0, 0, 2'b01, 2'b00};
    tbl[2] = '{1, 0, 3, 1, 0, 0, 0, 2'b01, 2'b00};
    tbl[3] = '{1, 0, 4, 1, 0, 0, 0, 2'b01, 2'b00};
    tbl[4] = '{0, 1, 0, 1, 1, 1, 0, 2'b00, 2'b01};
    tbl[5] = '{0, 1, 0, 1, 1, 2, 0, 2'b00, 2'b01};
    tbl[6] = '{0, 1, 0, 1, 1, 3, 0, 2'b00, 2'b01};
    tbl[7] = '{0, 1, 0, 1, 1, 4, 1, 2'b00, 2'b01};
    tbl[8] = '{0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00};

    // Reset state and the basic write-then-drain block.
    do_reset();
    check_reset_vals();
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].nd, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_out_last", i), 32'(bus.out_last), 32'(tbl[i].e_last));
      chk($sformatf("tbl%0d_bank_nd", i), 32'(bus.bank_nd), 32'(tbl[i].e_bnd));
      chk($sformatf("tbl%0d_bank_read", i), 32'(bus.bank_read), 32'(tbl[i].e_brd));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_out_m", i), 32'(bus.out_m), 32'(tbl[i].e_m));
      advance();
    end

    // Both banks full: in_ready drops, a further write is rejected and flagged.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 4'(i + 5));
    apply(1, 0, 4'hf);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_bank_nd", 32'(bus.bank_nd), 32'd0);
    advance();
    apply(0, 0, 0);
    chk("full_error", 32'(bus.error), 32'd1);
    advance();

    // Read with nothing to drain right after reset.
    do_reset();
    apply(0, 1, 0);
    chk("empty_bank_read", 32'(bus.bank_read), 32'd0);
    advance();
    apply(0, 0, 0);
    chk("empty_error", 32'(bus.error), 32'd1);
`ifdef MSTORE_SCHED_ERRCNT_EN
    chk("empty_err_count", 32'(err_count), 32'd1);
`endif
    advance();

    // Streaming: after the first block, write and read every cycle without stalls.
    do_reset();
    for (int i = 0; i < N; i++) step(1, 0, 4'(i + 9));
    for (int i = 0; i < 12; i++) begin
      apply(1, 1, 4'($urandom_range(0, 15)));
      chk("stream_opposite", 32'(bus.bank_nd ^ bus.bank_read), 32'd3);
      chk("stream_error", 32'(bus.error), 32'd0);
      advance();
    end

    // Reset in the middle of a block, then a fresh block round-trips.
    do_reset();
    step(1, 0, 4'h7);
    step(1, 0, 4'h8);
    do_reset();
    check_reset_vals();
    for (int i = 0; i < N; i++) step(1, 0, 4'(i + 11));
    for (int i = 0; i < N; i++) step(0, 1, 0);
    apply(0, 0, 0);
    chk("midrst_drained", 32'(bus.out_valid), 32'd0);
    advance();

    // Random traffic, mostly legal with occasional protocol violations.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int  nblk;
      bit  nd, rd;
      nblk = filled - drained;
      nd = (nblk < 2) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 2);
      rd = (nblk > 0) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 2);
      step(nd, rd, 4'($urandom_range(0, 15)));
      if (i == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
